// File: rtl/opcode_decode_stage_pkg.sv
// opcode_decode_stage_pkg: shared one-hot decode helper and skid state encoding
package opcode_decode_stage_pkg;

    localparam int MAX_OP_W = 8;
    localparam int MAX_CTRL_W = 1 << MAX_OP_W;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;

    function automatic logic [MAX_CTRL_W-1:0] onehot_dec(input logic [MAX_OP_W-1:0] op);
        return MAX_CTRL_W'(1) << op;
    endfunction

endpackage

// File: rtl/opcode_decode_stage_skid_buf.sv
// skid_buf: 1-entry valid/ready skid register with a registered ready
module skid_buf
    import opcode_decode_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t state, state_nxt;
    logic [WIDTH-1:0] skid_data;
    logic accept, load, full;

    assign full     = (state == SKID_FULL);
    assign in_ready = ~full;
    assign accept   = in_valid & in_ready;
    assign load     = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SKID_EMPTY;
        else        state <= state_nxt;
    end

    // FULL always implies a valid output register, so load means a transfer there
    always_comb begin
        state_nxt = state;
        state_nxt = full ? (load ? SKID_EMPTY : SKID_FULL)
                         : ((accept && !load) ? SKID_FULL : SKID_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            if (load) out_valid <= full | accept;
            if (load && (full || accept)) out_data <= full ? skid_data : in_data;
            if (accept && !load) skid_data <= in_data;
        end
    end

endmodule

// File: rtl/opcode_decode_stage.sv
// opcode_decode_stage: registered, mask-gated one-hot opcode decoder with illegal counter
module opcode_decode_stage
    import opcode_decode_stage_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_opcode,
    input  logic [(1<<OP_W)-1:0]   en_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(1<<OP_W)-1:0]   out_ctrl,
    output logic [OP_W-1:0]        out_opcode,
    output logic                   out_illegal,
    output logic [CNT_W-1:0]       illegal_cnt,
    input  logic                   cnt_clr
);

    localparam int CTRL_W = 1 << OP_W;
    localparam int PW = 1 + OP_W + CTRL_W;

    logic              dec_illegal;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [PW-1:0]     out_data;
    logic              ill_xfer;

    // decode happens before the skid so later mask changes never touch accepted beats
    assign dec_illegal = ~en_mask[in_opcode];
    assign dec_ctrl    = dec_illegal ? '0 : CTRL_W'(onehot_dec(MAX_OP_W'(in_opcode)));

    skid_buf #(.WIDTH(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({dec_illegal, in_opcode, dec_ctrl}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {out_illegal, out_opcode, out_ctrl} = out_data;
    assign ill_xfer = out_valid & out_ready & out_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      illegal_cnt <= '0;
        else if (cnt_clr)                illegal_cnt <= CNT_W'(ill_xfer);
        else if (ill_xfer && ~&illegal_cnt) illegal_cnt <= illegal_cnt + 1'b1;
    end

endmodule

// File: tb/tb_opcode_decode_stage.sv
// tb_opcode_decode_stage: table-driven and directed checks of the decode stage
module tb_opcode_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_opcode = '0;
    logic [7:0] en_mask = 8'hFF;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_ctrl;
    logic [2:0] out_opcode;
    logic       out_illegal;
    logic [1:0] illegal_cnt;
    logic       cnt_clr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    opcode_decode_stage #(.OP_W(3), .CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .en_mask     (en_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_opcode  (out_opcode),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt),
        .cnt_clr     (cnt_clr)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] mask;
        logic [7:0] ctrl;
        logic       ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string name, input logic [2:0] op, input logic [7:0] ctrl, input logic ill);
        chk({name, " valid"}, out_valid, 1);
        chk({name, " ctrl"}, out_ctrl, ctrl);
        chk({name, " opcode"}, out_opcode, op);
        chk({name, " illegal"}, out_illegal, ill);
    endtask

    vec_t vecs[12];
    logic [1:0] sat_seq[6];
    logic [1:0] exp_cnt;

    initial begin
        vecs[0]  = '{3'd0, 8'hFF, 8'h01, 1'b0};
        vecs[1]  = '{3'd1, 8'hFF, 8'h02, 1'b0};
        vecs[2]  = '{3'd2, 8'hFF, 8'h04, 1'b0};
        vecs[3]  = '{3'd3, 8'hFF, 8'h08, 1'b0};
        vecs[4]  = '{3'd4, 8'hFF, 8'h10, 1'b0};
        vecs[5]  = '{3'd5, 8'hFF, 8'h20, 1'b0};
        vecs[6]  = '{3'd6, 8'hFF, 8'h40, 1'b0};
        vecs[7]  = '{3'd7, 8'hFF, 8'h80, 1'b0};
        vecs[8]  = '{3'd3, 8'hF7, 8'h00, 1'b1};
        vecs[9]  = '{3'd4, 8'hF7, 8'h10, 1'b0};
        vecs[10] = '{3'd0, 8'hFE, 8'h00, 1'b1};
        vecs[11] = '{3'd7, 8'h7F, 8'h00, 1'b1};
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        #23 rst_n = 1'b1;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_ctrl", out_ctrl, 0);
        chk("reset out_opcode", out_opcode, 0);
        chk("reset out_illegal", out_illegal, 0);
        chk("reset illegal_cnt", illegal_cnt, 0);
        chk("reset in_ready", in_ready, 1);
        step();

        // back-to-back stream, one beat per cycle with 1-cycle latency
        exp_cnt = 2'd0;
        for (int i = 0; i < 12; i++) begin
            in_valid  = 1'b1;
            in_opcode = vecs[i].op;
            en_mask   = vecs[i].mask;
            step();
            beat($sformatf("vec%0d", i), vecs[i].op, vecs[i].ctrl, vecs[i].ill);
            chk($sformatf("vec%0d in_ready", i), in_ready, 1);
            chk($sformatf("vec%0d cnt", i), illegal_cnt, exp_cnt);
            if (vecs[i].ill && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
        end
        in_valid = 1'b0;
        step();
        chk("drain out_valid", out_valid, 0);
        chk("drain cnt", illegal_cnt, exp_cnt);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr alone cnt", illegal_cnt, 0);

        // stall: 5 held, 6 in skid, 7 waits
        en_mask = 8'hFF;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_opcode = 3'd5;
        step();
        beat("stall5", 3'd5, 8'h20, 1'b0);
        chk("stall5 in_ready", in_ready, 1);
        in_opcode = 3'd6;
        step();
        beat("stall6 held5", 3'd5, 8'h20, 1'b0);
        chk("stall6 in_ready", in_ready, 0);
        in_opcode = 3'd7;
        step();
        beat("stall7 held5", 3'd5, 8'h20, 1'b0);
        chk("stall7 in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        beat("release6", 3'd6, 8'h40, 1'b0);
        chk("release in_ready", in_ready, 1);
        step();
        beat("release7", 3'd7, 8'h80, 1'b0);
        in_valid = 1'b0;
        step();
        chk("release drain", out_valid, 0);

        // mask change after accept must not alter a parked beat
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_opcode = 3'd1;
        step();
        in_opcode = 3'd2;
        step();
        chk("mask skid in_ready", in_ready, 0);
        in_valid = 1'b0;
        en_mask = 8'hFB;
        step();
        beat("mask held1", 3'd1, 8'h02, 1'b0);
        out_ready = 1'b1;
        step();
        beat("mask beat2", 3'd2, 8'h04, 1'b0);
        step();
        chk("mask drain", out_valid, 0);
        chk("mask cnt", illegal_cnt, 0);

        // saturation of the 2-bit counter
        en_mask = 8'h00;
        in_opcode = 3'd0;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k < 6);
            step();
            if (k >= 1) chk($sformatf("sat cnt%0d", k), illegal_cnt, sat_seq[k-1]);
        end
        chk("sat drain", out_valid, 0);
        in_valid = 1'b1;
        step();
        beat("clr+ill", 3'd0, 8'h00, 1'b1);
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        step();
        chk("clr with ill cnt", illegal_cnt, 1);
        step();
        cnt_clr = 1'b0;
        chk("clr alone cnt2", illegal_cnt, 0);

        // async reset with the skid full
        en_mask = 8'hFF;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_opcode = 3'd3;
        step();
        in_opcode = 3'd4;
        step();
        chk("pre-rst in_ready", in_ready, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst in_ready", in_ready, 1);
        chk("async rst ctrl", out_ctrl, 0);
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post-rst no stale", out_valid, 0);
        in_valid = 1'b1;
        in_opcode = 3'd6;
        step();
        beat("post-rst new", 3'd6, 8'h40, 1'b0);
        in_valid = 1'b0;
        step();
        chk("post-rst drain", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
